// File: rtl/arith_pkg.sv
// Shared definitions for the 16-bit arithmetic unit and its result stage.
//   SEL_*     : operation codes presented on the unit's select input
//   is_arith  : select belongs to the flag-updating add/sub group
//   is_chain  : select is a chained multi-word op (ADC/SBB)
package arith_pkg;

    localparam logic [3:0] SEL_ADD = 4'b0000;
    localparam logic [3:0] SEL_SUB = 4'b0001;
    localparam logic [3:0] SEL_ADC = 4'b0010;
    localparam logic [3:0] SEL_SBB = 4'b0011;

    function automatic logic is_arith(input logic [3:0] select);
        return select[3:2] == 2'b00;
    endfunction

    function automatic logic is_chain(input logic [3:0] select);
        return select[3:1] == 3'b001;
    endfunction

endpackage

// File: rtl/arith_result_fifo.sv
// Small result buffer with valid/ready on both sides.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : write side; in_ready = (count < DEPTH)
//   in_data               : payload written on push
//   out_valid/out_ready   : read side; out_valid = (count != 0)
//   out_data              : head payload, forced to 0 while empty
module arith_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends on count only; no combinational path from out_ready.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; out_data masking hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/arith_result_stage.sv
// Registered result stage behind the arithmetic unit. Holds the
// architectural carry/zero flags (carry feeds back to the unit's carry_in)
// and buffers {select, zero, carry, result} entries for writeback.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   in_valid/in_ready            : upstream handshake
//   in_result/in_carry/in_compare: unit outputs for the presented op
//   in_select                    : op code that produced the result
//   flag_clear                   : synchronous clear / chain restart
//   flag_carry, flag_zero        : architectural flags
//   out_valid/out_ready          : writeback handshake
//   out_result/out_carry/out_zero/out_select : head entry fields
module arith_result_stage
    import arith_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_compare,
    input  logic [3:0]       in_select,
    input  logic             flag_clear,
    output logic             flag_carry,
    output logic             flag_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic [3:0]       out_select
);

    localparam int PAY_W = WIDTH + 6;

    logic             push;
    logic             prior_carry;
    logic             prior_zero;
    logic             carry_n;
    logic             zero_n;
    logic [PAY_W-1:0] fifo_in;
    logic [PAY_W-1:0] fifo_out;

    assign push = in_valid & in_ready;

    // A clear coinciding with a push starts a fresh chain: carry 0, zero 1.
    always_comb begin
        prior_carry = flag_clear ? 1'b0 : flag_carry;
        prior_zero  = flag_clear ? 1'b1 : flag_zero;
        carry_n     = prior_carry;
        zero_n      = prior_zero;
        if (is_arith(in_select)) begin
            carry_n = in_carry;
            zero_n  = is_chain(in_select) ? (prior_zero & in_compare) : in_compare;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_carry <= 1'b0;
            flag_zero  <= 1'b0;
        end else if (push) begin
            flag_carry <= carry_n;
            flag_zero  <= zero_n;
        end else if (flag_clear) begin
            flag_carry <= 1'b0;
            flag_zero  <= 1'b0;
        end
    end

    assign fifo_in = {in_select, zero_n, carry_n, in_result};

    arith_result_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(PAY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (fifo_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (fifo_out)
    );

    assign out_result = fifo_out[WIDTH-1:0];
    assign out_carry  = fifo_out[WIDTH];
    assign out_zero   = fifo_out[WIDTH+1];
    assign out_select = fifo_out[WIDTH+5:WIDTH+2];

endmodule

// File: tb/tb_arith_result_stage.sv
module tb_arith_result_stage;

    localparam int DEPTH = 2;
    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             in_compare;
    logic [3:0]       in_select;
    logic             flag_clear;
    logic             flag_carry;
    logic             flag_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic [3:0]       out_select;

    arith_result_stage #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_carry  (in_carry),
        .in_compare(in_compare),
        .in_select (in_select),
        .flag_clear(flag_clear),
        .flag_carry(flag_carry),
        .flag_zero (flag_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_select(out_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of entries plus two flag bits.
    typedef struct {
        logic [WIDTH-1:0] r;
        bit               c;
        bit               z;
        logic [3:0]       s;
    } ent_t;

    ent_t m_q[$];
    bit   m_c;
    bit   m_z;

    always @(posedge clk or negedge rst_n) begin
        bit   do_push;
        bit   do_pop;
        bit   pc;
        bit   pz;
        ent_t e;
        if (!rst_n) begin
            m_q.delete();
            m_c = 0;
            m_z = 0;
        end else begin
            do_push = in_valid && (m_q.size() < DEPTH);
            do_pop  = out_ready && (m_q.size() > 0);
            pc = flag_clear ? 1'b0 : m_c;
            pz = flag_clear ? 1'b1 : m_z;
            if (do_push) begin
                e.r = in_result;
                e.s = in_select;
                e.c = pc;
                e.z = pz;
                if (in_select <= 4'd1) begin
                    e.c = in_carry;
                    e.z = in_compare;
                end else if (in_select <= 4'd3) begin
                    e.c = in_carry;
                    e.z = pz && in_compare;
                end
                m_c = e.c;
                m_z = e.z;
            end else if (flag_clear) begin
                m_c = 0;
                m_z = 0;
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_flags", {flag_carry, flag_zero}, 0);
            chk("rst_out_result", out_result, 0);
        end else begin
            chk("in_ready", in_ready, m_q.size() < DEPTH);
            chk("out_valid", out_valid, m_q.size() > 0);
            chk("flag_carry", flag_carry, m_c);
            chk("flag_zero", flag_zero, m_z);
            if (m_q.size() > 0) begin
                chk("out_result", out_result, m_q[0].r);
                chk("out_carry", out_carry, m_q[0].c);
                chk("out_zero", out_zero, m_q[0].z);
                chk("out_select", out_select, m_q[0].s);
            end else begin
                chk("empty_mask", {out_select, out_zero, out_carry, out_result}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] sel, input logic [15:0] res,
                         input logic c, input logic z);
        in_valid   = v;
        in_select  = sel;
        in_result  = res;
        in_carry   = c;
        in_compare = z;
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        flag_clear = 1'b0;
        drive(0, 4'd0, 16'h0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_flags", {flag_carry, flag_zero}, 2'b00);

        // Push one entry, then reset mid-cycle.
        drive(1, 4'd0, 16'h1234, 1, 0);
        tick();
        drive(0, 4'd0, 16'h0, 0, 0);
        chk("pre_rst_valid", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_result", out_result, 16'h0);
        chk("async_rst_carry", flag_carry, 0);
        chk("async_rst_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", out_valid, 0);

        // Two-word add.
        drive(1, 4'd0, 16'hFFFF, 1, 0);
        tick();
        chk("add_flags", {flag_carry, flag_zero}, 2'b10);
        drive(1, 4'd2, 16'h0000, 0, 1);
        tick();
        drive(0, 4'd0, 16'h0, 0, 0);
        chk("adc_flags", {flag_carry, flag_zero}, 2'b00);
        out_ready = 1'b1;
        chk("head1", {out_result, out_carry, out_zero}, {16'hFFFF, 1'b1, 1'b0});
        tick();
        chk("head2", {out_result, out_carry, out_zero}, {16'h0000, 1'b0, 1'b0});
        tick();
        chk("drained", out_valid, 0);

        // Chained zero true, then a non-arith op keeps flags.
        drive(1, 4'd0, 16'h0000, 0, 1);
        tick();
        drive(1, 4'd3, 16'h0000, 1, 1);
        tick();
        chk("sbb_chain_zero", {flag_carry, flag_zero}, 2'b11);
        drive(1, 4'd4, 16'h5555, 0, 0);
        tick();
        drive(0, 4'd0, 16'h0, 0, 0);
        chk("nonarith_flags", {flag_carry, flag_zero}, 2'b11);
        chk("nonarith_entry", {out_select, out_carry, out_zero, out_result},
            {4'd4, 1'b1, 1'b1, 16'h5555});
        tick();
        out_ready = 1'b0;

        // Backpressure: A, B fill; C held.
        drive(1, 4'd0, 16'h000A, 0, 0);
        tick();
        drive(1, 4'd1, 16'h000B, 1, 1);
        tick();
        chk("full_ready", in_ready, 0);
        chk("flags_b", {flag_carry, flag_zero}, 2'b11);
        drive(1, 4'd0, 16'h000C, 0, 0);
        tick();
        chk("held_flags", {flag_carry, flag_zero}, 2'b11);
        chk("held_ready", in_ready, 0);
        out_ready = 1'b1;
        chk("order_a", out_result, 16'h000A);
        tick();
        chk("order_b", out_result, 16'h000B);
        chk("ready_after_pop", in_ready, 1);
        chk("flags_still_b", {flag_carry, flag_zero}, 2'b11);
        tick();
        drive(0, 4'd0, 16'h0, 0, 0);
        chk("order_c", out_result, 16'h000C);
        chk("flags_c", {flag_carry, flag_zero}, 2'b00);
        tick();
        chk("bp_drained", out_valid, 0);
        out_ready = 1'b0;

        // Simultaneous push/pop at count 1 across pointer wraps.
        drive(1, 4'd0, 16'h0100, 0, 0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 4'd1, 16'h0200 + 16'(i), i[0], 0);
            tick();
            chk("pp_head", out_result, 16'h0200 + 16'(i));
            chk("pp_count1", {out_valid, in_ready}, 2'b11);
        end
        drive(1, 4'd0, 16'h0300, 0, 0);
        tick();

        // flag_clear with ADC, then clear alone.
        flag_clear = 1'b1;
        drive(1, 4'd2, 16'h0000, 1, 1);
        tick();
        chk("clr_adc_flags", {flag_carry, flag_zero}, 2'b11);
        chk("clr_adc_entry", {out_carry, out_zero, out_select}, {1'b1, 1'b1, 4'd2});
        drive(0, 4'd0, 16'h0, 0, 0);
        out_ready = 1'b0;
        tick();
        flag_clear = 1'b0;
        chk("clr_only_flags", {flag_carry, flag_zero}, 2'b00);
        chk("clr_fifo_kept", {out_valid, out_carry, out_zero}, 3'b111);
        out_ready = 1'b1;
        tick();
        tick();
        chk("end_empty", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
